// File: rtl/pipe_pkg.sv
// Shared pipeline-stage types: skid state encoding, occupancy
// constants and default payload widths.
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_TWO   = 2'd2
  } ps_state_e;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_CTRL_W = 8;
  localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins).
module pipe_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic 2-entry skid pipeline register with flush and bubble masking.
// Define PIPE_STAGE_ELASTIC_PERF_EN to add stall/bubble counters.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_ELASTIC_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  ps_state_e         state_d, state_q;
  logic [DATA_W-1:0] main_data_d, main_data_q;
  logic [CTRL_W-1:0] main_ctrl_d, main_ctrl_q;
  logic [DATA_W-1:0] skid_data_d, skid_data_q;
  logic [CTRL_W-1:0] skid_ctrl_d, skid_ctrl_q;
  logic              in_fire;

  // Handshake outputs come straight from the state register.
  assign out_valid = (state_q != PS_EMPTY);
  assign in_ready  = (state_q != PS_TWO);
  assign in_fire   = in_valid & in_ready;
  assign occupancy = state_q;
  assign out_data  = main_data_q;
  assign out_ctrl  = out_valid ? main_ctrl_q : '0;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    case (state_q)
      PS_EMPTY: begin
        if (in_fire) begin
          main_data_d = in_data;
          main_ctrl_d = in_ctrl;
          state_d     = PS_ONE;
        end
      end
      PS_ONE: begin
        if (in_fire && out_ready) begin
          main_data_d = in_data;
          main_ctrl_d = in_ctrl;
        end else if (in_fire) begin
          skid_data_d = in_data;
          skid_ctrl_d = in_ctrl;
          state_d     = PS_TWO;
        end else if (out_ready) begin
          state_d = PS_EMPTY;
        end
      end
      PS_TWO: begin
        if (out_ready) begin
          main_data_d = skid_data_q;
          main_ctrl_d = skid_ctrl_q;
          state_d     = PS_ONE;
        end
      end
      default: state_d = PS_EMPTY;
    endcase
    // Flush kills everything; data is left as don't-care.
    if (flush) begin
      state_d     = PS_EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PS_EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

`ifdef PIPE_STAGE_ELASTIC_PERF_EN
  pipe_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (out_valid & ~out_ready),
    .cnt   (stall_cnt)
  );

  pipe_sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (~out_valid),
    .cnt   (bubble_cnt)
  );
`else
  logic [CNT_W-1:0] cnt_unused;
  assign cnt_unused = '0;
`endif

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised, elastic inter-stage pipeline register for the MIPS32 pipeline. Generalises the fixed E2M/M2W-style register.
- Carries an arbitrary data payload plus a separately-clearable control payload: reg_write, mem_write, hi/lo write and similar, which must be zeroed on a bubble.
- Adds a valid/ready handshake, a 2-entry skid buffer (full throughput, no combinational ready path), synchronous flush and an occupancy report.
- Instantiated between any two stages, e.g. EX->MEM, with DATA_W/CTRL_W sized per stage.

Parameters:
- DATA_W, 32, width of data payload (alu_out, write_data, pc_plus_4, ...); not cleared on flush.
- CTRL_W, 8, width of control payload; zeroed on reset/flush and masked when not valid.
- CNT_W, 16, width of performance counters (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  upstream stage presents a transaction.
- in_ready  out  1  stage can accept; depends on state register only.
- in_data  in  DATA_W  upstream data payload.
- in_ctrl  in  CTRL_W  upstream control payload.
- flush  in  1  synchronous kill of all held and incoming transactions.
- out_valid  out  1  downstream transaction present.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  DATA_W  head data payload.
- out_ctrl  out  CTRL_W  head control payload; all-zero whenever out_valid=0.
- occupancy  out  2  entries held: 0, 1 or 2.

Behaviour:
- Reset and interface:
  - Reset is asynchronous, active-low on rst_n; clock is clk.
  - Reset state: EMPTY, out_valid=0, out_data=0, out_ctrl=0, occupancy=0, in_ready=1.
  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main register (head) and skid register. States EMPTY(0), ONE(1), TWO(2).
  - occupancy = state encoding.
  - out_valid = (state != EMPTY).
  - in_ready = (state != TWO).
- EMPTY:
  - in_fire -> main<=in, ONE.
  - Otherwise hold.
- ONE:
  - in_fire & out_fire -> main<=in, stay ONE.
  - in_fire & !out_ready -> skid<=in, TWO.
  - out_fire only -> EMPTY.
  - Otherwise hold.
- TWO:
  - No in_fire is possible.
  - out_fire -> main<=skid, ONE.
  - Otherwise hold all contents.
- Latency and throughput:
  - Latency is 1 cycle: data captured at edge N is on out_* after edge N.
  - Sustained throughput is 1 transaction/cycle when out_ready=1.
- Flush:
  - Highest priority. At the next edge the state goes to EMPTY and main/skid ctrl are cleared to 0.
  - Data registers keep their values; they are don't-care.
  - A transaction offered during the flush cycle is dropped even if in_fire=1.
  - A concurrent out_fire still counts as delivered downstream.
- Masking: out_ctrl = out_valid ? main_ctrl : 0, evaluated combinationally on the registered state.
- Stall: out_ready=0 holds out_* stable. At most one further beat is absorbed, into the skid register.
- Reset mid-operation: all contents are discarded immediately (asynchronous) and the reset values above apply.

Optional Feature:
- Macro: PIPE_STAGE_ELASTIC_PERF_EN.
- When defined, the following are added:
  - output stall_cnt[CNT_W]: counts cycles with out_valid & !out_ready.
  - output bubble_cnt[CNT_W]: counts cycles with out_valid=0 after reset.
  - Both counters reset to 0, saturate at all-ones and clear on flush.
- When undefined, the ports and logic are absent.

Decomposition:
- Shared package pipe_pkg holds:
  - state typedef (PS_EMPTY=2'd0, PS_ONE=2'd1, PS_TWO=2'd2);
  - occupancy constants;
  - default widths.
- One sub-module, pipe_sat_counter (width-parametrised saturating counter with clear), is instantiated twice under the macro.

Test Plan:
- Reset: assert rst_n=0 mid-traffic with occupancy=2 -> immediately out_valid=0, out_ctrl=0, occupancy=0, in_ready=1.
- Streaming: in_valid=1, out_ready=1, data 0x1..0x8 on consecutive cycles -> out_data 0x1..0x8 one cycle later, no gaps, occupancy=1 throughout.
- Skid: send 0xA then 0xB with out_ready=0 ->
  - occupancy=2 and in_ready=0 after the 2nd edge;
  - out_data holds 0xA;
  - after raising out_ready, outputs are 0xA then 0xB.
- Flush: occupancy=2, ctrl=0xFF, flush=1 with in_valid=1 (data 0xC) -> next cycle out_valid=0, out_ctrl=0x00, 0xC never appears.
- Simultaneous: in ONE, in_fire & out_fire with data 0xD -> stays ONE, out_data=0xD next cycle.
- PERF (macro on): out_ready=0 for 5 cycles with out_valid=1 -> stall_cnt=5; with CNT_W=2, 10 stall cycles -> stall_cnt=3 (saturated).
